// File: rtl/viterbi_decoder_k3_if.sv
// Symbol stream into the K=3 Viterbi decoder and the decoded bit stream out.
// The channel side drives the symbols; the decoder drives the decoded bit.
interface viterbi_decoder_k3_if;
  logic       enable;
  logic [1:0] d_in;
  logic       d_out;

  modport master (output enable, output d_in, input d_out);
  modport slave  (input enable, input d_in, output d_out);
endinterface

// File: rtl/viterbi_decoder_k3.sv
// Hard-decision Viterbi decoder for the rate-1/2 K=3 code (g0=111, g1=101).
// Register-exchange survivors; one symbol in and one decoded bit out per enabled clock.
module viterbi_decoder_k3 #(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 8
) (
  input logic                clk,
  input logic                rst,
  viterbi_decoder_k3_if.slave bus
);

  localparam logic [PM_W-1:0] PM_INIT = PM_W'(2 ** (PM_W - 2));

  // Stored survivors drop their oldest bit: it is only ever needed one step
  // later, where it becomes bit TB_DEPTH-1 of the freshly extended path.
  logic [3:0][PM_W-1:0]     pm;
  logic [3:0][TB_DEPTH-2:0] sv;
  logic                     d_out_q;

  logic [3:0][PM_W-1:0]     cand0;
  logic [3:0][PM_W-1:0]     cand1;
  logic [3:0][PM_W-1:0]     raw_pm;
  logic [3:0][PM_W-1:0]     new_pm;
  logic [3:0][TB_DEPTH-1:0] new_sv;
  logic [3:0]               sel;
  logic [PM_W-1:0]          min_pm;
  logic [1:0]               best;

  function automatic logic [PM_W-1:0] branch_cand(
    input logic [PM_W-1:0] pm_val,
    input logic [1:0]      sym,
    input logic            b,
    input logic            s1,
    input logic            s0
  );
    logic [1:0]    diff;
    logic [PM_W:0] sum;
    diff = sym ^ {b ^ s1 ^ s0, b ^ s0};
    sum  = {1'b0, pm_val} + (PM_W+1)'(diff[1]) + (PM_W+1)'(diff[0]);
    return sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
  endfunction

  // Next state {b,x} is reached from {x,0} or {x,1}; ties keep the s0=0 predecessor.
  always_comb begin
    for (int ns = 0; ns < 4; ns++) begin
      cand0[ns]  = branch_cand(pm[{ns[0], 1'b0}], bus.d_in, ns[1], ns[0], 1'b0);
      cand1[ns]  = branch_cand(pm[{ns[0], 1'b1}], bus.d_in, ns[1], ns[0], 1'b1);
      sel[ns]    = cand1[ns] < cand0[ns];
      raw_pm[ns] = sel[ns] ? cand1[ns] : cand0[ns];
      new_sv[ns] = {sv[{ns[0], sel[ns]}], ns[1]};
    end
  end

  always_comb begin
    min_pm = raw_pm[0];
    best   = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (raw_pm[i] < min_pm) begin
        min_pm = raw_pm[i];
        best   = 2'(i);
      end
    end
    for (int i = 0; i < 4; i++) begin
      new_pm[i] = raw_pm[i] - min_pm;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm      <= {{3{PM_INIT}}, {PM_W{1'b0}}};
      sv      <= '0;
      d_out_q <= 1'b0;
    end else if (bus.enable) begin
      pm <= new_pm;
      for (int i = 0; i < 4; i++) begin
        sv[i] <= new_sv[i][TB_DEPTH-2:0];
      end
      d_out_q <= new_sv[best][TB_DEPTH-1];
    end
  end

  assign bus.d_out = d_out_q;

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Scoreboard bench for viterbi_decoder_k3: an encoder model feeds expected decoded
// bits into a queue, and a monitor compares them on every enabled edge.
module tb_viterbi_decoder_k3;

  localparam int TB_DEPTH = 16;
  localparam int PM_W     = 8;
  localparam int PM_INIT  = 64;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  viterbi_decoder_k3_if bus ();

  viterbi_decoder_k3 #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  bit exp_q[$];
  bit data_hist[$];
  bit enc_s1, enc_s0;

  bit check_data = 1'b1;
  bit zero_phase = 1'b0;
  bit have_last  = 1'b0;
  bit last_exp   = 1'b0;

  logic mon_en;
  bit   mon_exp;
  int   mon_min, mon_max;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h at time %0t", name, actual, required, $time);
    end
  endtask

  // The encoder model works from its own two-bit history; the expected decoded
  // bit is simply the data bit TB_DEPTH-1 symbols back, or zero before that.
  task automatic applyStimulus(input bit b, input bit [1:0] flip);
    bit [1:0] sym;
    int       idx;
    sym    = {b ^ enc_s1 ^ enc_s0, b ^ enc_s0};
    enc_s0 = enc_s1;
    enc_s1 = b;
    data_hist.push_back(b);
    idx = data_hist.size() - 1;
    @(negedge clk);
    bus.enable = 1'b1;
    bus.d_in   = sym ^ flip;
    exp_q.push_back((idx >= TB_DEPTH - 1) ? data_hist[idx - TB_DEPTH + 1] : 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.enable = 1'b0;
      bus.d_in   = 2'($urandom);
    end
  endtask

  task automatic run_stream(input int n, input bit with_errors, input bit with_gaps);
    bit [1:0] flip;
    for (int i = 0; i < n; i++) begin
      flip = 2'b00;
      if (with_errors && (i % 8 == 4)) flip = ((i / 8) % 2 != 0) ? 2'b10 : 2'b01;
      applyStimulus(1'($urandom), flip);
      if (with_gaps && $urandom_range(0, 2) == 0) idle($urandom_range(1, 5));
    end
  endtask

  // Asserts reset between clock edges so the async clear is visible at once.
  task automatic assert_reset();
    rst = 1'b0;
    #1;
    checkOutput("reset_d_out", bus.d_out, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("reset_pm%0d", i), dut.pm[i], (i == 0) ? 0 : PM_INIT);
    end
    exp_q.delete();
    data_hist.delete();
    enc_s1     = 1'b0;
    enc_s0     = 1'b0;
    have_last  = 1'b0;
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  always begin
    @(posedge clk);
    if (rst === 1'b1) begin
      mon_en = bus.enable;
      #1;
      if (mon_en === 1'b1) begin
        mon_min = dut.pm[0];
        mon_max = dut.pm[0];
        for (int i = 1; i < 4; i++) begin
          if (dut.pm[i] < mon_min) mon_min = dut.pm[i];
          if (dut.pm[i] > mon_max) mon_max = dut.pm[i];
        end
        checkOutput("pm_min_zero", mon_min, 0);
        checkOutput("pm_no_wrap", (mon_max > PM_INIT + 2) ? 1 : 0, 0);
        checkOutput("d_out_known", $isunknown(bus.d_out) ? 1 : 0, 0);
        if (zero_phase) checkOutput("pm00_zero", dut.pm[0], 0);
        if (check_data) begin
          if (exp_q.size() == 0) begin
            checkOutput("scoreboard_underflow", 1, 0);
          end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("d_out_decoded", bus.d_out, mon_exp);
            last_exp  = mon_exp;
            have_last = 1'b1;
          end
        end
      end else if (have_last) begin
        checkOutput("d_out_hold", bus.d_out, last_exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.d_in   = 2'b00;
    enc_s1     = 1'b0;
    enc_s0     = 1'b0;
    #3;
    assert_reset();

    zero_phase = 1'b1;
    for (int i = 0; i < 100; i++) applyStimulus(1'b0, 2'b00);
    idle(1);
    zero_phase = 1'b0;

    applyStimulus(1'b1, 2'b00);
    for (int i = 0; i < 30; i++) applyStimulus(1'b0, 2'b00);

    run_stream(256, 1'b1, 1'b0);
    run_stream(256, 1'b1, 1'b1);

    run_stream(40, 1'b1, 1'b0);
    #2;
    assert_reset();
    run_stream(64, 1'b1, 1'b0);
    idle(2);

    check_data = 1'b0;
    have_last  = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.d_in   = 2'($urandom);
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
